// File: rtl/vga_pkg.sv
// Shared constants and helpers for the switch-conditioning front end of the VGA path.
package vga_pkg;

  localparam int SW_WIDTH_DEF     = 12;
  localparam int TICK_DIV_DEF     = 100000;
  localparam int STABLE_TICKS_DEF = 20;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int CNT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_db_bit.sv
// One switch bit: two-flop synchroniser, tick-paced stability counter,
// registered debounced level and rise/fall strobes.
module db_bit
  import vga_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic strobe_next
);

  localparam int CW = CNT_W(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_reg, sync2_reg;
  logic          db_reg, db_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    db_next   = db_reg;
    cnt_next  = cnt_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    // Any agreement restarts the window, even between ticks.
    if (sync2_reg == db_reg) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg == CNT_LAST) begin
        db_next   = sync2_reg;
        cnt_next  = '0;
        rise_next = sync2_reg;
        fall_next = ~sync2_reg;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= RST_VAL;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
      db_reg    <= db_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign db          = db_reg;
  assign rise        = rise_reg;
  assign fall        = fall_reg;
  assign strobe_next = rise_next | fall_next;

endmodule

// File: rtl/sw_debounce.sv
// Debounces the slide-switch bank: shared sample-tick prescaler, one db_bit per
// switch, and a registered any-bit-changed strobe aligned with rise/fall.
module sw_debounce
  import vga_pkg::*;
#(
  parameter int                  SW_WIDTH     = SW_WIDTH_DEF,
  parameter int                  TICK_DIV     = TICK_DIV_DEF,
  parameter int                  STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic [SW_WIDTH-1:0] RST_VAL      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] sw_db,
  output logic [SW_WIDTH-1:0] sw_rise,
  output logic [SW_WIDTH-1:0] sw_fall,
  output logic                sw_changed,
  output logic                tick
);

  localparam int PW = CNT_W(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       pre_reg, pre_next;
  logic                tick_reg, tick_next;
  logic                changed_reg;
  logic [SW_WIDTH-1:0] strobe_next;

  always_comb begin
    pre_next  = (pre_reg == PRE_LAST) ? '0 : pre_reg + PW'(1);
    tick_next = (pre_reg == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg     <= '0;
      tick_reg    <= 1'b0;
      changed_reg <= 1'b0;
    end else begin
      pre_reg     <= pre_next;
      tick_reg    <= tick_next;
      changed_reg <= |strobe_next;
    end
  end

  generate
    for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : g_bit
      db_bit #(
        .STABLE_TICKS(STABLE_TICKS),
        .RST_VAL     (RST_VAL[gi])
      ) u_bit (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick_reg),
        .sw_raw     (sw_in[gi]),
        .db         (sw_db[gi]),
        .rise       (sw_rise[gi]),
        .fall       (sw_fall[gi]),
        .strobe_next(strobe_next[gi])
      );
    end
  endgenerate

  assign tick       = tick_reg;
  assign sw_changed = changed_reg;

endmodule
